// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core's memory access stage.
//   - funct3 encodings for load/store access size and sign
//   - mem_state_t: data-memory handshake FSM states
//   - is_misaligned(): natural-alignment check for an access
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_t;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic r_mis;
    r_mis = 1'b0;
    case (funct3[1:0])
      2'b01:   r_mis = addr_lo[0];
      2'b10:   r_mis = (addr_lo != 2'b00);
      default: r_mis = 1'b0;
    endcase
    return r_mis;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering between the core datapath and a 32-bit data memory.
// Purely combinational.
//   i_funct3      access size/sign
//   i_addr_lo     byte offset within the word
//   i_store_data  store data from the register file
//   i_rdata       raw word returned by the memory
//   o_be          byte enables for the request
//   o_wdata       store data replicated onto the active lanes
//   o_load_data   selected and extended load result
//   o_misaligned  access violates natural alignment (only with MEM_MISALIGN_TRAP_EN)
module load_store_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_load_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            o_misaligned
`endif
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Misaligned offsets fall back to the naturally aligned lane: a[0] is
  // ignored for halves and the whole offset is ignored for words.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {(XLEN/8){i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {(XLEN/16){i_store_data[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
      end
    endcase
  end

  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_H:    o_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_HU:   o_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign o_misaligned = is_misaligned(i_funct3, i_addr_lo);
`endif

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage RISC-V core.
// Consumes the EX/MEM register, runs the data-memory req/gnt/rvalid
// handshake, resolves branches and produces the MEM/WB register.
// Optional: define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses and
// report them on misalign_o instead of truncating the address.
// Ports:
//   clk_i, reset_i (async, active-low)
//   *_MEMORYACCESS        EX/MEM register contents (held stable during stall_o)
//   dmem_*                data-memory request/response interface
//   stall_o               freezes PC, IF/ID, ID/EX and EX/MEM
//   PCSrc_o, PCTarget_o   branch resolution (combinational)
//   *_WRITEBACK           MEM/WB register
//   misalign_o            misaligned-access flag (MEM_MISALIGN_TRAP_EN only)
module memory_access_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [XLEN-1:0]   ALUResult_MEMORYACCESS,
  input  logic [XLEN-1:0]   ReadData2_MEMORYACCESS,
  input  logic [2:0]        funct3_MEMORYACCESS,
  input  logic [4:0]        Write_Register_MEMORYACCESS,
  input  logic              MemtoReg_MEMORYACCESS,
  input  logic              MemWrite_MEMORYACCESS,
  input  logic              MemRead_MEMORYACCESS,
  input  logic              RegWrite_MEMORYACCESS,
  input  logic              Branch_MEMORYACCESS,
  input  logic              zero_MEMORYACCESS,
  input  logic [XLEN-1:0]   PCTarget_MEMORYACCESS,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              stall_o,
  output logic              PCSrc_o,
  output logic [XLEN-1:0]   PCTarget_o,
  output logic [XLEN-1:0]   ReadData_WRITEBACK,
  output logic [XLEN-1:0]   ALUResult_WRITEBACK,
  output logic [4:0]        Write_Register_WRITEBACK,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              RegWrite_WRITEBACK,
  output logic              MemtoReg_WRITEBACK
);

  mem_state_t r_state;
  mem_state_t w_state_d;

  logic            w_access;
  logic            w_access_eff;
  logic            w_is_load;
  logic            w_done;
  logic            w_req;
  logic            w_stall;
  logic [XLEN-1:0] w_load_data;

  logic [XLEN-1:0] r_read_data;
  logic [XLEN-1:0] r_alu_result;
  logic [4:0]      r_write_reg;
  logic            r_reg_write;
  logic            r_mem_to_reg;

  // MemRead wins when both controls are set, so the op is treated as a load.
  assign w_access  = MemRead_MEMORYACCESS | MemWrite_MEMORYACCESS;
  assign w_is_load = MemRead_MEMORYACCESS;

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misaligned;
  logic w_trap;
  logic r_misalign;

  assign w_trap       = w_access & w_misaligned;
  assign w_access_eff = w_access & ~w_misaligned;
`else
  assign w_access_eff = w_access;
`endif

  load_store_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_funct3     (funct3_MEMORYACCESS),
    .i_addr_lo    (ALUResult_MEMORYACCESS[1:0]),
    .i_store_data (ReadData2_MEMORYACCESS),
    .i_rdata      (dmem_rdata_i),
    .o_be         (dmem_be_o),
    .o_wdata      (dmem_wdata_o),
    .o_load_data  (w_load_data)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .o_misaligned (w_misaligned)
`endif
  );

  always_comb begin
    w_state_d = r_state;
    w_done    = 1'b0;
    w_req     = 1'b0;
    case (r_state)
      IDLE: begin
        w_req = w_access_eff;
        if (w_access_eff) begin
          if (dmem_gnt_i) begin
            if (w_is_load) w_state_d = WAIT_RSP;
            else           w_done    = 1'b1;
          end else begin
            w_state_d = REQ;
          end
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (dmem_gnt_i) begin
          if (w_is_load) begin
            w_state_d = WAIT_RSP;
          end else begin
            w_state_d = IDLE;
            w_done    = 1'b1;
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          w_state_d = IDLE;
          w_done    = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= IDLE;
    else          r_state <= w_state_d;
  end

  assign w_stall = w_access_eff & ~w_done;
  assign stall_o = w_stall;

  // Gate with reset so an in-flight request drops immediately on reset.
  assign dmem_req_o  = w_req & reset_i;
  assign dmem_we_o   = MemWrite_MEMORYACCESS & ~MemRead_MEMORYACCESS;
  assign dmem_addr_o = {ALUResult_MEMORYACCESS[ADDR_W-1:2], 2'b00};

  assign PCSrc_o    = Branch_MEMORYACCESS & zero_MEMORYACCESS;
  assign PCTarget_o = PCTarget_MEMORYACCESS;

  // MEM/WB register; a stall cycle inserts a bubble and keeps the data fields.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_write_reg  <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (w_stall) begin
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_read_data  <= w_load_data;
      r_alu_result <= ALUResult_MEMORYACCESS;
      r_write_reg  <= Write_Register_MEMORYACCESS;
`ifdef MEM_MISALIGN_TRAP_EN
      r_reg_write  <= RegWrite_MEMORYACCESS & ~w_trap;
`else
      r_reg_write  <= RegWrite_MEMORYACCESS;
`endif
      r_mem_to_reg <= MemtoReg_MEMORYACCESS;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_misalign <= 1'b0;
    else          r_misalign <= w_trap & ~w_stall;
  end
  assign misalign_o = r_misalign;
`endif

  assign ReadData_WRITEBACK       = r_read_data;
  assign ALUResult_WRITEBACK      = r_alu_result;
  assign Write_Register_WRITEBACK = r_write_reg;
  assign RegWrite_WRITEBACK       = r_reg_write;
  assign MemtoReg_WRITEBACK       = r_mem_to_reg;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] alu_i, sd_i, pct_i;
  logic [2:0]  f3_i;
  logic [4:0]  rd_i;
  logic        m2r_i, mw_i, mr_i, rw_i, br_i, zr_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'h0;
  logic        stall_o, PCSrc_o;
  logic [31:0] PCTarget_o, ReadData_WRITEBACK, ALUResult_WRITEBACK;
  logic [4:0]  Write_Register_WRITEBACK;
  logic        RegWrite_WRITEBACK, MemtoReg_WRITEBACK;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i                       (clk),
    .reset_i                     (reset_i),
    .ALUResult_MEMORYACCESS      (alu_i),
    .ReadData2_MEMORYACCESS      (sd_i),
    .funct3_MEMORYACCESS         (f3_i),
    .Write_Register_MEMORYACCESS (rd_i),
    .MemtoReg_MEMORYACCESS       (m2r_i),
    .MemWrite_MEMORYACCESS       (mw_i),
    .MemRead_MEMORYACCESS        (mr_i),
    .RegWrite_MEMORYACCESS       (rw_i),
    .Branch_MEMORYACCESS         (br_i),
    .zero_MEMORYACCESS           (zr_i),
    .PCTarget_MEMORYACCESS       (pct_i),
    .dmem_req_o                  (dmem_req_o),
    .dmem_we_o                   (dmem_we_o),
    .dmem_addr_o                 (dmem_addr_o),
    .dmem_be_o                   (dmem_be_o),
    .dmem_wdata_o                (dmem_wdata_o),
    .dmem_gnt_i                  (dmem_gnt_i),
    .dmem_rvalid_i               (dmem_rvalid_i),
    .dmem_rdata_i                (dmem_rdata_i),
    .stall_o                     (stall_o),
    .PCSrc_o                     (PCSrc_o),
    .PCTarget_o                  (PCTarget_o),
    .ReadData_WRITEBACK          (ReadData_WRITEBACK),
    .ALUResult_WRITEBACK         (ALUResult_WRITEBACK),
    .Write_Register_WRITEBACK    (Write_Register_WRITEBACK),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o                  (misalign_o),
`endif
    .RegWrite_WRITEBACK          (RegWrite_WRITEBACK),
    .MemtoReg_WRITEBACK          (MemtoReg_WRITEBACK)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] alu, sd, rdata, pct;
    logic [4:0]  rd;
    logic        mr, mw, rw, m2r, br, zr, noise;
    int          gdel, rdel;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_rdwb;
    int          e_stalls;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference lane rules in plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned a = addr % 4;
    logic [31:0] b = (rd >> (8 * a)) % 256;
    logic [31:0] h = (rd >> (16 * (a / 2))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b - 32'd256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned a = addr % 4;
    case (f3[1:0])
      2'b00:   return 4'(1 << a);
      2'b01:   return 4'(3 << (2 * (a / 2)));
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return (sd % 256) * 32'h0101_0101;
      2'b01:   return (sd % 65536) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic vec_t mkv(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sd,
                               input logic [31:0] rdata, input logic mr, input logic mw,
                               input int gdel, input int rdel, input logic [31:0] e_addr,
                               input logic [3:0] e_be, input logic [31:0] e_wdata,
                               input logic [31:0] e_rdwb, input int e_stalls);
    vec_t v;
    v.f3 = f3; v.alu = alu; v.sd = sd; v.rdata = rdata;
    v.mr = mr; v.mw = mw; v.rw = mr; v.m2r = mr;
    v.rd = alu[4:0] | 5'd1; v.pct = alu ^ 32'h0000_F000;
    v.br = 1'b0; v.zr = alu[2]; v.noise = alu[0];
    v.gdel = gdel; v.rdel = rdel;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rdwb = e_rdwb;
    v.e_stalls = e_stalls;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    f3_i = v.f3; alu_i = v.alu; sd_i = v.sd; pct_i = v.pct; rd_i = v.rd;
    mr_i = v.mr; mw_i = v.mw; rw_i = v.rw; m2r_i = v.m2r; br_i = v.br; zr_i = v.zr;
  endtask

  // Entered at posedge+1; returns at posedge+1 after the op retires into MEM/WB.
  task automatic do_op(input vec_t v, input int id);
    bit acc = v.mr | v.mw;
    bit ld = v.mr;
    bit granted = 0;
    bit fin = 0;
    bit last, exp_req, exp_stall;
    int cyc = 0;
    int waits = 0;
    int nstall = 0;
    apply(v);
    while (!fin && cyc < 64) begin
      last = 0;
      if (!acc) begin
        exp_req = 0; last = 1;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = ~v.rdata;
      end else if (!granted) begin
        exp_req = 1;
        dmem_gnt_i = (cyc >= v.gdel);
        dmem_rvalid_i = v.noise;
        dmem_rdata_i = ~v.rdata;
        last = dmem_gnt_i && !ld;
      end else begin
        exp_req = 0;
        dmem_gnt_i = 0;
        dmem_rvalid_i = (waits == v.rdel);
        dmem_rdata_i = dmem_rvalid_i ? v.rdata : ~v.rdata;
        last = dmem_rvalid_i;
      end
      exp_stall = acc && !last;
      @(negedge clk);
      chk($sformatf("op%0d c%0d req", id, cyc), 32'(dmem_req_o), 32'(exp_req));
      chk($sformatf("op%0d c%0d stall", id, cyc), 32'(stall_o), 32'(exp_stall));
      if (cyc == 0) begin
        chk($sformatf("op%0d pcsrc", id), 32'(PCSrc_o), 32'(v.br & v.zr));
        chk($sformatf("op%0d pctarget", id), PCTarget_o, v.pct);
      end
      if (exp_req) begin
        chk($sformatf("op%0d addr", id), dmem_addr_o, v.e_addr);
        chk($sformatf("op%0d we", id), 32'(dmem_we_o), 32'(!ld));
        if (!ld) begin
          chk($sformatf("op%0d be", id), 32'(dmem_be_o), 32'(v.e_be));
          chk($sformatf("op%0d wdata", id), dmem_wdata_o, v.e_wdata);
        end
      end
      if (stall_o) nstall++;
      if (acc && !granted && dmem_gnt_i) granted = 1;
      else if (granted && !dmem_rvalid_i) waits++;
      fin = last;
      @(posedge clk);
      #1;
      dmem_gnt_i = 0;
      dmem_rvalid_i = 0;
      if (!fin) begin
        chk($sformatf("op%0d bubble rw", id), 32'(RegWrite_WRITEBACK), 32'd0);
        chk($sformatf("op%0d bubble m2r", id), 32'(MemtoReg_WRITEBACK), 32'd0);
      end
      cyc++;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL op%0d timeout: got no completion after %0d cycles, required completion", id,
               cyc);
    end
    chk($sformatf("op%0d stall_cycles", id), 32'(nstall), 32'(v.e_stalls));
    chk($sformatf("op%0d wb_rw", id), 32'(RegWrite_WRITEBACK), 32'(v.rw));
    chk($sformatf("op%0d wb_m2r", id), 32'(MemtoReg_WRITEBACK), 32'(v.m2r));
    chk($sformatf("op%0d wb_rd", id), 32'(Write_Register_WRITEBACK), 32'(v.rd));
    chk($sformatf("op%0d wb_alu", id), ALUResult_WRITEBACK, v.alu);
    if (ld) chk($sformatf("op%0d wb_rdata", id), ReadData_WRITEBACK, v.e_rdwb);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int kind = $urandom_range(0, 2);
    logic [2:0] f3 = (kind == 2) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
    logic [31:0] alu = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01) alu[0] = 1'b0;
    if (f3[1:0] == 2'b10) alu[1:0] = 2'b00;
`endif
    v = mkv(f3, alu, $urandom, $urandom, kind == 1, kind == 2, $urandom_range(0, 3),
            $urandom_range(0, 2), alu & ~32'h3, 4'h0, 32'h0, 32'h0, 0);
    v.e_be = ref_be(f3, alu);
    v.e_wdata = ref_wdata(f3, v.sd);
    v.e_rdwb = ref_load(f3, alu, v.rdata);
    v.e_stalls = (kind == 1) ? v.gdel + 1 + v.rdel : (kind == 2) ? v.gdel : 0;
    if (kind == 1 && $urandom_range(0, 3) == 0) v.mw = 1'b1;
    v.rw = $urandom_range(0, 1);
    v.m2r = $urandom_range(0, 1);
    v.br = $urandom_range(0, 1);
    v.noise = $urandom_range(0, 1);
    return v;
  endfunction

  vec_t tbl[$];
  vec_t t;

  initial begin
    // Reset state, with a load presented so a request would otherwise appear.
    t = mkv(F3_W, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 32'h100, 4'h0, 32'h0, 32'h0, 1);
    apply(t);
    #1 reset_i = 1'b0;
    #10;
    chk("reset req", 32'(dmem_req_o), 32'd0);
    chk("reset wb_alu", ALUResult_WRITEBACK, 32'h0);
    chk("reset wb_rdata", ReadData_WRITEBACK, 32'h0);
    chk("reset wb_rd", 32'(Write_Register_WRITEBACK), 32'd0);
    chk("reset wb_rw", 32'(RegWrite_WRITEBACK), 32'd0);
    chk("reset wb_m2r", 32'(MemtoReg_WRITEBACK), 32'd0);
    @(negedge clk);
    mr_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: f3, addr, store data, rdata, mr, mw, gdel, rdel,
    // exp addr, exp be, exp wdata, exp load result, exp stall cycles.
    tbl.push_back(mkv(F3_B, 32'h1003, 32'hAB, 32'h0, 0, 1, 0, 0,
                      32'h1000, 4'b1000, 32'hABAB_ABAB, 32'h0, 0));
    tbl.push_back(mkv(F3_H, 32'h2002, 32'h0, 32'h8001_1234, 1, 0, 2, 0,
                      32'h2000, 4'h0, 32'h0, 32'hFFFF_8001, 3));
    // Byte lane 2 holds 0xF0; lane 1 holds 0x00.
    tbl.push_back(mkv(F3_BU, 32'h12, 32'h0, 32'h00F0_0000, 1, 0, 0, 0,
                      32'h10, 4'h0, 32'h0, 32'h0000_00F0, 1));
    tbl.push_back(mkv(F3_BU, 32'h11, 32'h0, 32'h00F0_0000, 1, 0, 0, 0,
                      32'h10, 4'h0, 32'h0, 32'h0000_0000, 1));
    tbl.push_back(mkv(F3_H, 32'h1002, 32'h1234_BEEF, 32'h0, 0, 1, 0, 0,
                      32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0));
    tbl.push_back(mkv(F3_W, 32'h1004, 32'hDEAD_BEEF, 32'h0, 0, 1, 1, 0,
                      32'h1004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1));
    tbl.push_back(mkv(F3_W, 32'h2008, 32'h0, 32'h1234_5678, 1, 0, 0, 2,
                      32'h2008, 4'h0, 32'h0, 32'h1234_5678, 3));
    tbl.push_back(mkv(F3_B, 32'h2003, 32'h0, 32'h8000_0000, 1, 0, 0, 0,
                      32'h2000, 4'h0, 32'h0, 32'hFFFF_FF80, 1));
    tbl.push_back(mkv(F3_HU, 32'h2002, 32'h0, 32'h8001_1234, 1, 0, 0, 0,
                      32'h2000, 4'h0, 32'h0, 32'h0000_8001, 1));
    // MemRead and MemWrite together behave as a load.
    tbl.push_back(mkv(F3_B, 32'h2001, 32'h0, 32'h0000_7F00, 1, 1, 1, 1,
                      32'h2000, 4'h0, 32'h0, 32'h0000_007F, 3));
    t = mkv(F3_W, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    t.br = 1'b1; t.zr = 1'b1; t.pct = 32'h40;
    tbl.push_back(t);
    t.zr = 1'b0; t.pct = 32'h80;
    tbl.push_back(t);
    t = mkv(F3_W, 32'h55, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    t.rw = 1'b1;
    tbl.push_back(t);
`ifndef MEM_MISALIGN_TRAP_EN
    tbl.push_back(mkv(F3_W, 32'h3002, 32'h0, 32'hA5A5_1234, 1, 0, 0, 0,
                      32'h3000, 4'h0, 32'h0, 32'hA5A5_1234, 1));
    tbl.push_back(mkv(F3_H, 32'h1001, 32'h0000_CAFE, 32'h0, 0, 1, 0, 0,
                      32'h1000, 4'b0011, 32'hCAFE_CAFE, 32'h0, 0));
`endif
    foreach (tbl[i]) do_op(tbl[i], i);

    // Reset while a load waits for its response.
    t = mkv(F3_W, 32'hCAFE, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    t.rw = 1'b1; t.m2r = 1'b1; t.rd = 5'd7;
    do_op(t, 100);
    t = mkv(F3_W, 32'h100, 32'h0, 32'h0, 1, 0, 0, 0, 32'h100, 4'h0, 32'h0, 32'h0, 1);
    apply(t);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("rst_seq grant req", 32'(dmem_req_o), 32'd1);
    @(posedge clk);
    #1 dmem_gnt_i = 1'b0;
    @(negedge clk);
    chk("rst_seq wait req", 32'(dmem_req_o), 32'd0);
    chk("rst_seq wait stall", 32'(stall_o), 32'd1);
    #2 reset_i = 1'b0;
    #1;
    chk("rst_seq req", 32'(dmem_req_o), 32'd0);
    chk("rst_seq wb_alu", ALUResult_WRITEBACK, 32'h0);
    chk("rst_seq wb_rdata", ReadData_WRITEBACK, 32'h0);
    chk("rst_seq wb_rd", 32'(Write_Register_WRITEBACK), 32'd0);
    chk("rst_seq wb_rw", 32'(RegWrite_WRITEBACK), 32'd0);
    chk("rst_seq wb_m2r", 32'(MemtoReg_WRITEBACK), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_seq misalign", 32'(misalign_o), 32'd0);
`endif
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    chk("rst_seq held req", 32'(dmem_req_o), 32'd0);
    @(negedge clk);
    mr_i = 1'b0; rw_i = 1'b0; m2r_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    // A fresh load must start in IDLE and ignore the stray rvalid during request.
    t = mkv(F3_W, 32'h104, 32'h0, 32'h1357_9BDF, 1, 0, 1, 0,
            32'h104, 4'h0, 32'h0, 32'h1357_9BDF, 2);
    t.noise = 1'b1;
    do_op(t, 101);

`ifdef MEM_MISALIGN_TRAP_EN
    t = mkv(F3_W, 32'h3002, 32'h0, 32'h0, 1, 0, 0, 0, 32'h3000, 4'h0, 32'h0, 32'h0, 0);
    apply(t);
    @(negedge clk);
    chk("mis_lw req", 32'(dmem_req_o), 32'd0);
    chk("mis_lw stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    chk("mis_lw misalign", 32'(misalign_o), 32'd1);
    chk("mis_lw wb_rw", 32'(RegWrite_WRITEBACK), 32'd0);
    t = mkv(F3_W, 32'h77, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    t.rw = 1'b1;
    apply(t);
    @(posedge clk);
    #1;
    chk("mis_clear misalign", 32'(misalign_o), 32'd0);
    chk("mis_clear wb_rw", 32'(RegWrite_WRITEBACK), 32'd1);
    t = mkv(F3_H, 32'h1001, 32'hCAFE, 32'h0, 0, 1, 0, 0, 32'h1000, 4'h0, 32'h0, 32'h0, 0);
    apply(t);
    @(negedge clk);
    chk("mis_sh req", 32'(dmem_req_o), 32'd0);
    chk("mis_sh stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    chk("mis_sh misalign", 32'(misalign_o), 32'd1);
    mw_i = 1'b0;
    @(posedge clk);
    #1;
    chk("mis_sh clear", 32'(misalign_o), 32'd0);
`endif

    for (int i = 0; i < 60; i++) begin
      t = rand_vec();
      do_op(t, 200 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
